// File: rtl/jtframe_sdram_pkg.sv
// Shared types for the SDRAM bank arbiter: FSM state encoding and bank index width helper.
package jtframe_sdram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RFSH  = 2'd3
    } arb_state_e;

    function automatic int unsigned bank_iw(input int unsigned banks);
        return (banks > 1) ? $clog2(banks) : 1;
    endfunction

endpackage

// File: rtl/jtframe_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', scanning cyclically.
module jtframe_rr_pick import jtframe_sdram_pkg::*; #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = bank_iw(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic          found;
    int unsigned   cand;
    logic [IW-1:0] cidx;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = 0;
        cidx    = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = (32'(last_i) + k) % N;
            cidx = IW'(cand);
            if (!found && req_i[cidx]) begin
                found         = 1'b1;
                grant_o[cidx] = 1'b1;
                idx_o         = cidx;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/jtframe_sdram_bank_arb.sv
// Round-robin arbiter sharing one single-issue SDRAM controller among bank requesters,
// with periodic auto-refresh slotted in between transactions.
module jtframe_sdram_bank_arb import jtframe_sdram_pkg::*; #(
    parameter int unsigned BANKS       = 4,
    parameter int unsigned SDRAMW      = 22,
    parameter int unsigned RFSH_PERIOD = 374
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [BANKS-1:0]        ba_rd_i,
    input  logic [BANKS-1:0]        ba_wr_i,
    input  logic [BANKS*SDRAMW-1:0] ba_addr_i,
    input  logic [BANKS*16-1:0]     ba_din_i,
    input  logic [BANKS*2-1:0]      ba_wrmask_i,
    output logic [BANKS-1:0]        ba_ack_o,
    output logic [BANKS-1:0]        ba_rdy_o,
    output logic [BANKS-1:0]        ba_dst_o,
    output logic [15:0]             ba_dout_o,
    output logic                    ctl_rd_o,
    output logic                    ctl_wr_o,
    output logic [SDRAMW-1:0]       ctl_addr_o,
    output logic [15:0]             ctl_din_o,
    output logic [1:0]              ctl_wrmask_o,
    input  logic                    ctl_ack_i,
    input  logic                    ctl_rdy_i,
    input  logic                    ctl_dst_i,
    input  logic [15:0]             ctl_dout_i,
    output logic                    ctl_rfsh_o,
    input  logic                    ctl_rfsh_ack_i,
    output logic                    rfsh_miss_o
);

    localparam int unsigned   IW       = bank_iw(BANKS);
    localparam logic [IW-1:0] LAST_RST = IW'(BANKS - 1);

    arb_state_e        state_q;
    logic [BANKS-1:0]  grant_q;
    logic [IW-1:0]     gidx_q;
    logic [IW-1:0]     last_q;
    logic              ctl_rd_q;
    logic              ctl_wr_q;
    logic              ctl_rfsh_q;
    logic [SDRAMW-1:0] ctl_addr_q;
    logic [15:0]       ctl_din_q;
    logic [1:0]        ctl_wrmask_q;
    logic              rfsh_pend_q;
    logic              rfsh_miss_q;
    logic              rfsh_done;

    logic [BANKS-1:0]  req;
    logic [BANKS-1:0]  pick_grant;
    logic [IW-1:0]     pick_idx;
    logic              pick_any;

    assign req = ba_rd_i | ba_wr_i;

    jtframe_rr_pick #(
        .N  (BANKS),
        .IW (IW)
    ) u_pick (
        .req_i   (req),
        .last_i  (last_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            gidx_q       <= '0;
            last_q       <= LAST_RST;
            ctl_rd_q     <= 1'b0;
            ctl_wr_q     <= 1'b0;
            ctl_rfsh_q   <= 1'b0;
            ctl_addr_q   <= '0;
            ctl_din_q    <= '0;
            ctl_wrmask_q <= 2'b11;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    // A pending refresh always wins over bank requests
                    if (rfsh_pend_q) begin
                        ctl_rfsh_q <= 1'b1;
                        state_q    <= ST_RFSH;
                    end else if (pick_any) begin
                        grant_q      <= pick_grant;
                        gidx_q       <= pick_idx;
                        ctl_addr_q   <= ba_addr_i[32'(pick_idx)*SDRAMW +: SDRAMW];
                        ctl_din_q    <= ba_din_i[32'(pick_idx)*16 +: 16];
                        ctl_wrmask_q <= ba_wrmask_i[32'(pick_idx)*2 +: 2];
                        ctl_wr_q     <= ba_wr_i[pick_idx];
                        ctl_rd_q     <= ~ba_wr_i[pick_idx];
                        state_q      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (ctl_ack_i) begin
                        ctl_rd_q <= 1'b0;
                        ctl_wr_q <= 1'b0;
                        if (ctl_rdy_i) begin
                            last_q  <= gidx_q;
                            grant_q <= '0;
                            state_q <= ST_IDLE;
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (ctl_rdy_i) begin
                        last_q  <= gidx_q;
                        grant_q <= '0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_RFSH: begin
                    if (ctl_rfsh_ack_i) begin
                        ctl_rfsh_q <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rfsh_done = (state_q == ST_RFSH) && ctl_rfsh_ack_i;

    if (RFSH_PERIOD > 0) begin : g_rfsh
        localparam int unsigned   CW     = (RFSH_PERIOD > 1) ? $clog2(RFSH_PERIOD) : 1;
        localparam logic [CW-1:0] RELOAD = CW'(RFSH_PERIOD - 1);

        logic [CW-1:0] cnt_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q       <= RELOAD;
                rfsh_pend_q <= 1'b0;
                rfsh_miss_q <= 1'b0;
            end else begin
                rfsh_miss_q <= 1'b0;
                if (cnt_q == '0) begin
                    cnt_q       <= RELOAD;
                    rfsh_pend_q <= 1'b1;
                    // Only one refresh may be outstanding; an unserved one is dropped
                    rfsh_miss_q <= rfsh_pend_q & ~rfsh_done;
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                    if (rfsh_done) rfsh_pend_q <= 1'b0;
                end
            end
        end
    end else begin : g_no_rfsh
        assign rfsh_pend_q = 1'b0;
        assign rfsh_miss_q = 1'b0;
    end

    always_comb begin
        ba_ack_o = (ctl_ack_i && state_q == ST_ISSUE) ? grant_q : '0;
        ba_rdy_o = (ctl_rdy_i && (state_q == ST_ISSUE || state_q == ST_WAIT)) ? grant_q : '0;
        ba_dst_o = ctl_dst_i ? grant_q : '0;
    end

    assign ba_dout_o    = ctl_dout_i;
    assign ctl_rd_o     = ctl_rd_q;
    assign ctl_wr_o     = ctl_wr_q;
    assign ctl_addr_o   = ctl_addr_q;
    assign ctl_din_o    = ctl_din_q;
    assign ctl_wrmask_o = ctl_wrmask_q;
    assign ctl_rfsh_o   = ctl_rfsh_q;
    assign rfsh_miss_o  = rfsh_miss_q;

endmodule
